// File: rtl/dmem_pkg.sv
// Shared definitions for the stalling data-memory responder: state encoding,
// busy-counter width and the reset value used for read data and storage.
package dmem_pkg;

  localparam int          CNT_W    = 4;
  localparam int          DATA_W   = 16;
  localparam logic [15:0] DATA_RST = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;

endpackage

// File: rtl/dff_ar.sv
// Plain D flop bank with asynchronous active-high reset to a parameterised value.
module dff_ar #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/dmem_array.sv
// Word storage for the responder: one synchronous write port, one combinational
// read port, every word cleared by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] widx,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] ridx,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array is reset word by word on purpose (it must read back as zero
  // after reset), which makes it flop storage rather than an inferable RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_RST;
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Stalling data-memory responder: captures a request, stays busy for LATENCY
// cycles, commits the access and pulses Done with registered read data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Enable,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        err
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [1:0]             state_raw_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   mis_q, mis_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_rdata;

  // Address bits above the word index alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[15:ADDR_BITS+1];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Enable) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_LOAD;
          idx_d   = Addr[ADDR_BITS:1];
          wdata_d = DataIn;
          wr_d    = Wr;
          mis_d   = Addr[0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Commit edge: aligned accesses touch the array or DataOut, misaligned ones neither.
          state_d = ST_DONE;
          if (!mis_q) begin
            if (wr_q) mem_we = 1'b1;
            else      dout_d = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dff_ar #(.W(2), .RST_VAL(ST_IDLE_ENC)) u_state_ff (
    .clk(clk), .rst(rst), .d(state_d), .q(state_raw_q)
  );
  assign state_q = state_e'(state_raw_q);

  dff_ar #(.W(CNT_W)) u_cnt_ff (
    .clk(clk), .rst(rst), .d(cnt_d), .q(cnt_q)
  );

  dff_ar #(.W(ADDR_BITS)) u_idx_ff (
    .clk(clk), .rst(rst), .d(idx_d), .q(idx_q)
  );

  dff_ar #(.W(DATA_W)) u_wdata_ff (
    .clk(clk), .rst(rst), .d(wdata_d), .q(wdata_q)
  );

  dff_ar #(.W(1)) u_wr_ff (
    .clk(clk), .rst(rst), .d(wr_d), .q(wr_q)
  );

  dff_ar #(.W(1)) u_mis_ff (
    .clk(clk), .rst(rst), .d(mis_d), .q(mis_q)
  );

  dff_ar #(.W(DATA_W), .RST_VAL(DATA_RST)) u_dout_ff (
    .clk(clk), .rst(rst), .d(dout_d), .q(dout_q)
  );

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (idx_q),
    .rdata (mem_rdata)
  );

  // The unused encoding raises err until the next edge returns to IDLE.
  assign Stall   = (state_q == ST_BUSY);
  assign Done    = (state_q == ST_DONE);
  assign err     = ((state_q == ST_DONE) && mis_q) || (state_q == ST_BAD);
  assign DataOut = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus LATENCY=1 and
// LATENCY=15 instances sharing the same request inputs.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] din;

  logic [2:0]  stall_v;
  logic [2:0]  done_v;
  logic [2:0]  err_v;
  logic [15:0] dout_v [3];

  int n_checks;
  int n_fail;

  // Index 0: LATENCY=2, index 1: LATENCY=1, index 2: LATENCY=15.
  dmem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .Enable(en), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(dout_v[0]), .Stall(stall_v[0]), .Done(done_v[0]), .err(err_v[0])
  );

  dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .Enable(en), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(dout_v[1]), .Stall(stall_v[1]), .Done(done_v[1]), .err(err_v[1])
  );

  dmem_responder #(.ADDR_BITS(8), .LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst(rst), .Enable(en), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(dout_v[2]), .Stall(stall_v[2]), .Done(done_v[2]), .err(err_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    en   = 1'b1;
    wr   = w;
    addr = a;
    din  = d;
    tick();
    en   = 1'b0;
  endtask

  task automatic wait_for(input int sel, output int stall_cyc);
    stall_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_v[sel]) break;
      if (stall_v[sel]) stall_cyc++;
      tick();
    end
    check("done_seen", {31'd0, done_v[sel]}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int s1, s15, d1, d15;
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    en   = 1'b0;
    wr   = 1'b0;
    addr = 16'h0000;
    din  = 16'h0000;

    #1;
    check("rst_stall", {31'd0, stall_v[0]}, 32'd0);
    check("rst_done",  {31'd0, done_v[0]},  32'd0);
    check("rst_err",   {31'd0, err_v[0]},   32'd0);
    check("rst_dout",  {16'd0, dout_v[0]},  32'h0000);
    tick();
    tick();
    rst = 1'b0;

    // Aligned write: two stall cycles, Done, DataOut untouched.
    issue(1'b1, 16'h0010, 16'hBEEF);
    wait_for(0, n);
    check("wr_stall_cycles", n, 32'd2);
    check("wr_err",  {31'd0, err_v[0]}, 32'd0);
    check("wr_dout", {16'd0, dout_v[0]}, 32'h0000);

    // Read presented during the DONE cycle of the write.
    issue(1'b0, 16'h0010, 16'h0000);
    wait_for(0, n);
    check("rd_stall_cycles", n, 32'd2);
    check("rd_dout", {16'd0, dout_v[0]}, 32'hBEEF);
    check("rd_err",  {31'd0, err_v[0]}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done_v[0]}, 32'd0);
    check("idle_stall",     {31'd0, stall_v[0]}, 32'd0);

    // Misaligned read of word 8: err, DataOut held.
    issue(1'b0, 16'h0211, 16'h0000);
    wait_for(0, n);
    check("mis_rd_err",  {31'd0, err_v[0]}, 32'd1);
    check("mis_rd_dout", {16'd0, dout_v[0]}, 32'hBEEF);

    // Misaligned write to word 8 must not reach the array.
    issue(1'b1, 16'h0011, 16'h5555);
    wait_for(0, n);
    check("mis_wr_err", {31'd0, err_v[0]}, 32'd1);
    issue(1'b0, 16'h0010, 16'h0000);
    wait_for(0, n);
    check("mis_wr_no_write", {16'd0, dout_v[0]}, 32'hBEEF);
    check("aligned_err_clear", {31'd0, err_v[0]}, 32'd0);

    // Upper address bits alias.
    issue(1'b1, 16'h0202, 16'h1234);
    wait_for(0, n);
    issue(1'b0, 16'h0002, 16'h0000);
    wait_for(0, n);
    check("alias_dout", {16'd0, dout_v[0]}, 32'h1234);

    // Reset during the second BUSY cycle drops the request immediately.
    tick();
    issue(1'b1, 16'h0004, 16'hAAAA);
    tick();
    check("busy2_stall", {31'd0, stall_v[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_stall", {31'd0, stall_v[0]}, 32'd0);
    check("async_rst_done",  {31'd0, done_v[0]},  32'd0);
    check("async_rst_dout",  {16'd0, dout_v[0]},  32'h0000);
    tick();
    rst = 1'b0;
    tick();
    check("no_done_after_rst", {31'd0, done_v[0]}, 32'd0);
    issue(1'b0, 16'h0004, 16'h0000);
    wait_for(0, n);
    check("dropped_write", {16'd0, dout_v[0]}, 32'h0000);

    // Reset and Enable together: not accepted.
    tick();
    rst  = 1'b1;
    en   = 1'b1;
    wr   = 1'b0;
    addr = 16'h0010;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    #1;
    check("rst_en_stall", {31'd0, stall_v[0]}, 32'd0);
    tick();
    check("rst_en_stall_next", {31'd0, stall_v[0]}, 32'd0);
    check("rst_en_done_next",  {31'd0, done_v[0]},  32'd0);

    // Stall width for LATENCY=1 and LATENCY=15 instances.
    pulse_reset();
    issue(1'b1, 16'h0020, 16'h5A5A);
    s1 = 0; s15 = 0; d1 = 0; d15 = 0;
    for (int i = 0; i < 20; i++) begin
      s1  += int'(stall_v[1]);
      s15 += int'(stall_v[2]);
      d1  += int'(done_v[1]);
      d15 += int'(done_v[2]);
      tick();
    end
    check("l1_stall_width",  s1,  32'd1);
    check("l15_stall_width", s15, 32'd15);
    check("l1_done_pulses",  d1,  32'd1);
    check("l15_done_pulses", d15, 32'd1);

    // LATENCY=15: Enable toggled with new Addr/DataIn while busy is ignored.
    pulse_reset();
    issue(1'b1, 16'h0020, 16'h5A5A);
    for (int i = 0; i < 14; i++) begin
      en   = i[0];
      wr   = 1'b1;
      addr = 16'h0030;
      din  = 16'hFFFF;
      tick();
    end
    en = 1'b0;
    wait_for(2, n);
    issue(1'b0, 16'h0020, 16'h0000);
    wait_for(2, n);
    check("l15_captured_data", {16'd0, dout_v[2]}, 32'h5A5A);
    issue(1'b0, 16'h0030, 16'h0000);
    wait_for(2, n);
    check("l15_ignored_addr", {16'd0, dout_v[2]}, 32'h0000);

    // LATENCY=1: a request held during the single BUSY cycle is ignored.
    pulse_reset();
    issue(1'b1, 16'h0040, 16'h1111);
    en   = 1'b1;
    wr   = 1'b1;
    addr = 16'h0042;
    din  = 16'h2222;
    tick();
    check("l1_done", {31'd0, done_v[1]}, 32'd1);
    en = 1'b0;
    issue(1'b0, 16'h0040, 16'h0000);
    wait_for(1, n);
    check("l1_captured_data", {16'd0, dout_v[1]}, 32'h1111);
    issue(1'b0, 16'h0042, 16'h0000);
    wait_for(1, n);
    check("l1_ignored_addr", {16'd0, dout_v[1]}, 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
